// File: rtl/aap_writeback_arbiter_pkg.sv
// Shared sizing defaults for the register-file write-back arbiter.
// Also holds a pointer-width helper that stays at least 1 bit wide.
package aap_writeback_arbiter_pkg;

   localparam int AAP_NUM_REQ = 4;
   localparam int AAP_ADDR_W  = 6;
   localparam int AAP_DATA_W  = 16;
   localparam int AAP_PTR_W   = $clog2(AAP_NUM_REQ);

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aap_writeback_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from start (wrapping) and returns
// the first requester that is valid and not excluded.
module aap_rr_pick
   import aap_writeback_arbiter_pkg::*;
#(
   parameter int N     = AAP_NUM_REQ,
   parameter int PTR_W = AAP_PTR_W
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] start,
   input  logic [N-1:0]     exclude,
   output logic             found,
   output logic [PTR_W-1:0] idx
);

   logic [N-1:0] cand;

   assign cand = valid & ~exclude;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && cand[(int'(start) + k) % N]) begin
            found = 1'b1;
            idx   = PTR_W'((int'(start) + k) % N);
         end
      end
   end

endmodule

// File: rtl/aap_writeback_arbiter.sv
// Round-robin arbiter sharing the two register-file write ports among
// NUM_REQ write-back requesters; never writes one register twice per cycle.
module aap_writeback_arbiter
   import aap_writeback_arbiter_pkg::*;
#(
   parameter int NUM_REQ = AAP_NUM_REQ,
   parameter int ADDR_W  = AAP_ADDR_W,
   parameter int DATA_W  = AAP_DATA_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         reg_wr1,
   output logic [DATA_W-1:0]         reg_wr1_data,
   output logic                      reg_wr1_enable,
   output logic [ADDR_W-1:0]         reg_wr2,
   output logic [DATA_W-1:0]         reg_wr2_data,
   output logic                      reg_wr2_enable,
   output logic                      busy
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
   logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;
   logic [NUM_REQ-1:0]             same_addr;
   logic [PTR_W-1:0]               rr_ptr;
   logic                           a_found, b_found;
   logic [PTR_W-1:0]               a_idx, b_idx;
   logic                           grant_a, grant_b;
   logic [ADDR_W-1:0]              a_addr;

   assign addr_arr = req_addr;
   assign data_arr = req_data;
   assign a_addr   = addr_arr[a_idx];

   // A's own slot matches too, so this mask also keeps B off A's index
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmp
      assign same_addr[i] = (addr_arr[i] == a_addr);
   end

   aap_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_a (
      .valid   (req_valid),
      .start   (rr_ptr),
      .exclude ('0),
      .found   (a_found),
      .idx     (a_idx)
   );

   aap_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_b (
      .valid   (req_valid),
      .start   (rr_ptr),
      .exclude (same_addr),
      .found   (b_found),
      .idx     (b_idx)
   );

   // No grants while reset is held, so nothing can be accepted and lost
   assign grant_a = a_found & reset;
   assign grant_b = b_found & a_found & reset;

   always_comb begin
      req_ready = '0;
      if (grant_a) req_ready[a_idx] = 1'b1;
      if (grant_b) req_ready[b_idx] = 1'b1;
   end

   assign busy = |(req_valid & ~req_ready);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return PTR_W'((int'(p) + 1) % NUM_REQ);
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr         <= '0;
         reg_wr1        <= '0;
         reg_wr1_data   <= '0;
         reg_wr1_enable <= 1'b0;
         reg_wr2        <= '0;
         reg_wr2_data   <= '0;
         reg_wr2_enable <= 1'b0;
      end else begin
         reg_wr1_enable <= grant_a;
         reg_wr2_enable <= grant_b;
         if (grant_a) begin
            reg_wr1      <= addr_arr[a_idx];
            reg_wr1_data <= data_arr[a_idx];
         end
         if (grant_b) begin
            reg_wr2      <= addr_arr[b_idx];
            reg_wr2_data <= data_arr[b_idx];
         end
         if (grant_b)      rr_ptr <= ptr_inc(b_idx);
         else if (grant_a) rr_ptr <= ptr_inc(a_idx);
      end
   end

endmodule

// File: tb/tb_aap_writeback_arbiter.sv
// Directed bench for aap_writeback_arbiter: vector table plus hand sequences
// for fairness and mid-stream reset.
module tb_aap_writeback_arbiter;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N*AW-1:0]   req_addr  = '0;
   logic [N*DW-1:0]   req_data  = '0;
   logic [N-1:0]      req_ready;
   logic [AW-1:0]     reg_wr1, reg_wr2;
   logic [DW-1:0]     reg_wr1_data, reg_wr2_data;
   logic              reg_wr1_enable, reg_wr2_enable;
   logic              busy;

   aap_writeback_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .reg_wr1        (reg_wr1),
      .reg_wr1_data   (reg_wr1_data),
      .reg_wr1_enable (reg_wr1_enable),
      .reg_wr2        (reg_wr2),
      .reg_wr2_data   (reg_wr2_data),
      .reg_wr2_enable (reg_wr2_enable),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic                  rst;
      int                    reps;
      logic [N-1:0]          valid;
      logic [N-1:0][AW-1:0]  addr;
      logic [N-1:0][DW-1:0]  data;
      logic [N-1:0]          rdy;
      logic                  bsy;
      logic                  en1;
      logic [AW-1:0]         wr1;
      logic [DW-1:0]         d1;
      logic                  en2;
      logic [AW-1:0]         wr2;
      logic [DW-1:0]         d2;
   } vec_t;

   vec_t tbl[10];

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic apply(input vec_t v, input int n);
      req_valid = v.valid;
      req_addr  = v.addr;
      req_data  = v.data;
      @(negedge clock);
      chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(v.rdy));
      chk($sformatf("v%0d_busy", n), 32'(busy), 32'(v.bsy));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_en1", n), 32'(reg_wr1_enable), 32'(v.en1));
      chk($sformatf("v%0d_wr1", n), 32'(reg_wr1), 32'(v.wr1));
      chk($sformatf("v%0d_d1", n), 32'(reg_wr1_data), 32'(v.d1));
      chk($sformatf("v%0d_en2", n), 32'(reg_wr2_enable), 32'(v.en2));
      chk($sformatf("v%0d_wr2", n), 32'(reg_wr2), 32'(v.wr2));
      chk($sformatf("v%0d_d2", n), 32'(reg_wr2_data), 32'(v.d2));
   endtask

   logic [N-1:0][AW-1:0] a14;
   logic [N-1:0][DW-1:0] d14;
   logic [N-1:0][AW-1:0] a_cf;
   logic [N-1:0][DW-1:0] d_cf;
   logic                 got;
   logic                 g0;

   initial begin
      a14  = {6'd4, 6'd3, 6'd2, 6'd1};
      d14  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
      a_cf = {6'd0, 6'd9, 6'd7, 6'd7};
      d_cf = {16'h0000, 16'h0999, 16'hBBBB, 16'hAAAA};

      // single requester
      tbl[0] = '{1'b1, 1, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {16'h0, 16'h0, 16'h0, 16'h1234},
                 4'b0001, 1'b0, 1'b1, 6'd5, 16'h1234, 1'b0, 6'd0, 16'h0};
      // all four valid, two per cycle
      tbl[1] = '{1'b1, 1, 4'b1111, a14, d14, 4'b0011, 1'b1, 1'b1, 6'd1, 16'h0011, 1'b1, 6'd2, 16'h0022};
      tbl[2] = '{1'b0, 1, 4'b1100, a14, d14, 4'b1100, 1'b0, 1'b1, 6'd3, 16'h0033, 1'b1, 6'd4, 16'h0044};
      // same-address conflict
      tbl[3] = '{1'b1, 1, 4'b0111, a_cf, d_cf, 4'b0101, 1'b1, 1'b1, 6'd7, 16'hAAAA, 1'b1, 6'd9, 16'h0999};
      tbl[4] = '{1'b0, 1, 4'b0010, a_cf, d_cf, 4'b0010, 1'b0, 1'b1, 6'd7, 16'hBBBB, 1'b0, 6'd9, 16'h0999};
      // idle: outputs hold, enables low
      tbl[5] = '{1'b0, 10, 4'b0000, a_cf, d_cf, 4'b0000, 1'b0, 1'b0, 6'd7, 16'hBBBB, 1'b0, 6'd9, 16'h0999};
      // pointer unchanged by idle (still 2)
      tbl[6] = '{1'b0, 1, 4'b1111, a14, d14, 4'b1100, 1'b1, 1'b1, 6'd3, 16'h0033, 1'b1, 6'd4, 16'h0044};
      // all same address: one grant per cycle
      tbl[7] = '{1'b0, 1, 4'b1111, {4{6'd5}}, {16'h0404, 16'h0303, 16'h0202, 16'h0101},
                 4'b0001, 1'b1, 1'b1, 6'd5, 16'h0101, 1'b0, 6'd4, 16'h0044};
      tbl[8] = '{1'b0, 1, 4'b1110, {4{6'd5}}, {16'h0404, 16'h0303, 16'h0202, 16'h0101},
                 4'b0010, 1'b1, 1'b1, 6'd5, 16'h0202, 1'b0, 6'd4, 16'h0044};
      // scan from 2 wraps: req3 on port 1, req0 on port 2
      tbl[9] = '{1'b0, 1, 4'b1001, {6'd11, 6'd0, 6'd0, 6'd10}, {16'h0B0B, 16'h0, 16'h0, 16'h0A0A},
                 4'b1001, 1'b0, 1'b1, 6'd11, 16'h0B0B, 1'b1, 6'd10, 16'h0A0A};

      // reset state
      #1;
      reset     = 1'b0;
      req_valid = 4'b1111;
      #2;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_en1", 32'(reg_wr1_enable), 32'h0);
      chk("rst_en2", 32'(reg_wr2_enable), 32'h0);
      chk("rst_wr1", 32'(reg_wr1), 32'h0);
      chk("rst_d2", 32'(reg_wr2_data), 32'h0);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) do_reset();
         for (int r = 0; r < tbl[i].reps; r++) apply(tbl[i], i);
      end

      // fairness: req0 always valid, req3 once, same address
      do_reset();
      req_addr  = {6'd20, 6'd0, 6'd0, 6'd20};
      req_data  = {16'h3333, 16'h0, 16'h0, 16'h1000};
      req_valid = 4'b1001;
      got = 1'b0;
      for (int c = 0; c < N && !got; c++) begin
         @(negedge clock);
         got = req_ready[3];
         g0  = req_ready[0];
         @(posedge clock);
         #1;
         if (g0) req_data[15:0] = req_data[15:0] + 16'h1;
         if (got) req_valid[3] = 1'b0;
      end
      chk("fair_req3_granted", 32'(got), 32'h1);
      chk("fair_wr1", 32'(reg_wr1), 32'd20);
      chk("fair_d1", 32'(reg_wr1_data), 32'h3333);
      // pointer wrapped 3->0: req0 takes port 1, req1 port 2
      req_addr[AW +: AW]  = 6'd21;
      req_data[DW +: DW]  = 16'h2121;
      req_valid           = 4'b0011;
      @(negedge clock);
      chk("wrap_ready", 32'(req_ready), 32'h3);
      @(posedge clock);
      #1;
      chk("wrap_wr1", 32'(reg_wr1), 32'd20);
      chk("wrap_d1", 32'(reg_wr1_data), 32'h1001);
      chk("wrap_wr2", 32'(reg_wr2), 32'd21);
      chk("wrap_d2", 32'(reg_wr2_data), 32'h2121);

      // reset mid-operation
      req_valid = 4'b1111;
      req_addr  = a14;
      req_data  = d14;
      @(posedge clock);
      #1;
      chk("mid_en1_hi", 32'(reg_wr1_enable), 32'h1);
      chk("mid_en2_hi", 32'(reg_wr2_enable), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_en1_lo", 32'(reg_wr1_enable), 32'h0);
      chk("mid_en2_lo", 32'(reg_wr2_enable), 32'h0);
      chk("mid_ready", 32'(req_ready), 32'h0);
      chk("mid_wr1_clr", 32'(reg_wr1), 32'h0);
      @(posedge clock);
      #1;
      chk("mid_en1_held", 32'(reg_wr1_enable), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rel_ready", 32'(req_ready), 32'h3);
      @(posedge clock);
      #1;
      chk("rel_wr1", 32'(reg_wr1), 32'd1);
      chk("rel_d1", 32'(reg_wr1_data), 32'h0011);
      chk("rel_wr2", 32'(reg_wr2), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aap_writeback_arbiter.md
Name: aap_writeback_arbiter

Overview:
- Shares the register file's two write ports (wr1, wr2) among NUM_REQ write-back requesters, e.g. execute ALU result, load unit, multi-cycle unit, special-register update.
- Uses valid/ready handshakes and round-robin fairness.
- Never issues two writes to the same register in one cycle.
- Sits between the execute stage(s) and the register file; the write-port outputs are registered.

Parameters:
- NUM_REQ, 4: number of write-back requesters (2..8).
- ADDR_W, 6: register index width (64 registers).
- DATA_W, 16: register data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a pending write.
- req_addr  in  NUM_REQ*ADDR_W  destination register; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data; requester i occupies slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  grant. The transfer occurs when valid and ready are both high at a rising edge.
- reg_wr1  out  ADDR_W  write port 1 register index.
- reg_wr1_data  out  DATA_W  write port 1 data.
- reg_wr1_enable  out  1  write port 1 strobe.
- reg_wr2  out  ADDR_W  write port 2 register index.
- reg_wr2_data  out  DATA_W  write port 2 data.
- reg_wr2_enable  out  1  write port 2 strobe.
- busy  out  1  high when any req_valid bit is high and that requester is not granted this cycle (stall indicator for the pipeline controller).

Behaviour:
- Reset (reset low, asynchronous):
  - reg_wr1/reg_wr2, their data and enables all go to 0.
  - Round-robin pointer rr_ptr goes to 0.
  - req_ready is forced to 0 while reset is low.
  - Any write accepted but not yet driven is discarded; no partial write is produced.
- Grant selection is combinational, each cycle:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first valid requester is grant A (port 1).
  - The next valid requester whose req_addr differs from A's address is grant B (port 2).
  - A valid requester with the same address as A is skipped this cycle; its ready stays 0.
  - At most 2 grants per cycle.
  - req_ready[i]=1 only for granted i, and only while req_valid[i]=1.
  - Requesters must not wait for ready before asserting valid. Once asserted, valid, addr and data stay stable until the transfer.
- Write-port latency is 1 cycle:
  - At the edge where grant A transfers, reg_wr1/reg_wr1_data latch A's addr/data and reg_wr1_enable=1 for exactly the following cycle.
  - Port 2 behaves the same for grant B.
  - An enable with no grant in a cycle is 0 in the following cycle.
  - The data/address outputs hold their last value while enable=0.
- Port mapping is fixed: a single grant always uses port 1; port 2 is used only with a simultaneous second grant.
- rr_ptr update at each edge:
  - two grants: (index of B)+1 mod NUM_REQ;
  - one grant: (index of A)+1 mod NUM_REQ;
  - no grant: unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, including under same-address conflicts.
- Ordering:
  - Two requesters targeting the same register are written in grant order, one per cycle.
  - The later-granted write lands last.
- Register 0 gets no special treatment; suppressing writes to it is the register file's concern.
- busy = |(req_valid & ~req_ready).
- Reset released mid-stream: arbitration restarts from requester 0 on the first edge after reset returns high.

Decomposition:
- Shared package / include file: ADDR_W and DATA_W defaults, NUM_REQ default, and a localparam for the pointer width, clog2(NUM_REQ).
- One sub-module: aap_rr_pick. It is combinational; given a valid mask, start pointer and exclude mask, it returns found and index. It is instantiated twice: once for A, and once for B with A's index and same-address requesters excluded.

Test Plan:
1. Single requester: reset low then high, req_valid=4'b0001, addr=5, data=16'h1234 -> req_ready[0]=1. Next cycle reg_wr1=5, reg_wr1_data=16'h1234, reg_wr1_enable=1, reg_wr2_enable=0. rr_ptr becomes 1.
2. All four valid, distinct addrs 1..4, rr_ptr=0:
   - cycle 0 grants req0→wr1, req1→wr2;
   - cycle 1 grants req2, req3;
   - busy=1 in cycle 0 and 0 in cycle 1 (all remaining requests granted).
3. Address conflict: req0 and req1 both addr=7 (data AAAA, BBBB), req2 addr=9 -> cycle 0 grants req0→wr1 and req2→wr2, req1 stalls. Cycle 1 grants req1→wr1. Register 7 ends holding BBBB.
4. Fairness: req0 valid continuously with new data each grant, req3 valid once -> req3 granted within 4 cycles, and rr_ptr wraps 3→0.
5. Reset mid-operation: assert reset low while enables are high -> enables drop to 0 immediately (asynchronous) and req_ready=0. After release, the first grant starts from req0.
6. Idle: no valid for 10 cycles -> both enables 0, rr_ptr unchanged, busy=0.
